demux1x2_8bits: RTL and testbench

Byte-stream splitter: the receive-side counterpart of the 2x1 8-bit mux with memory. A single 8-bit stream qualified by `valid_in` is dealt round-robin onto two output lanes (lane 0, lane 1), each with its own valid. Registered outputs; sits at the lane-splitting point of the PCIe physical-layer datapath, feeding two lane paths from one byte source.

---
 rtl/demux1x2_8bits.sv | 118 +++++++++++
 tb/tb_demux1x2_8bits.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_8bits.sv
// demux1x2_8bits: splits one valid-qualified byte stream round-robin onto two
// registered output lanes. The first byte after reset goes to lane 0.
// Optional build macro DEMUX_PAIR_ALIGN_EN: the lane-0 byte is held back and
// then released together with its lane-1 partner, so both lanes pulse valid
// on the same cycle.
module demux1x2_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] out0,
  output logic             valid_out0,
  output logic [WIDTH-1:0] out1,
  output logic             valid_out1,
  output logic             pending
);

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } sel_t;

  sel_t sel_reg, sel_next;

  logic [WIDTH-1:0] out0_next, out1_next;
  logic             valid_out0_next, valid_out1_next;
  logic             pending_next;

  // Lane selector register; reset always restarts the stream on lane 0.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_reg <= LANE0;
    end else begin
      sel_reg <= sel_next;
    end
  end

  // Selector toggles only on accepted bytes, so idle gaps never resync it.
  always_comb begin
    sel_next = sel_reg;
    if (valid_in) begin
      sel_next = (sel_reg == LANE0) ? LANE1 : LANE0;
    end
  end

`ifdef DEMUX_PAIR_ALIGN_EN
  logic [WIDTH-1:0] hold_reg, hold_next;

  // Lane-0 bytes wait in the hold register; the lane-1 byte releases the pair.
  always_comb begin
    out0_next       = out0;
    out1_next       = out1;
    valid_out0_next = 1'b0;
    valid_out1_next = 1'b0;
    pending_next    = pending;
    hold_next       = hold_reg;
    if (valid_in) begin
      if (sel_reg == LANE0) begin
        hold_next    = data_in;
        pending_next = 1'b1;
      end else begin
        out0_next       = hold_reg;
        out1_next       = data_in;
        valid_out0_next = 1'b1;
        valid_out1_next = 1'b1;
        pending_next    = 1'b0;
      end
    end
  end

  // Hold register; a reset mid-pair simply discards the held byte.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      hold_reg <= '0;
    end else begin
      hold_reg <= hold_next;
    end
  end
`else
  // Each accepted byte goes straight to the lane picked by the selector.
  always_comb begin
    out0_next       = out0;
    out1_next       = out1;
    valid_out0_next = 1'b0;
    valid_out1_next = 1'b0;
    pending_next    = 1'b0;
    if (valid_in) begin
      if (sel_reg == LANE0) begin
        out0_next       = data_in;
        valid_out0_next = 1'b1;
      end else begin
        out1_next       = data_in;
        valid_out1_next = 1'b1;
      end
    end
  end
`endif

  // Output registers; lane data holds its last value, only valids drop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out0       <= '0;
      out1       <= '0;
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
      pending    <= 1'b0;
    end else begin
      out0       <= out0_next;
      out1       <= out1_next;
      valid_out0 <= valid_out0_next;
      valid_out1 <= valid_out1_next;
      pending    <= pending_next;
    end
  end

endmodule

// File: tb/tb_demux1x2_8bits.sv
// Testbench for demux1x2_8bits: directed vectors, expected lane outputs queued
// by the stimulus thread and checked by an independent monitor.
module tb_demux1x2_8bits;

  logic       clk;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] out0, out1;
  logic       valid_out0, valid_out1, pending;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic       v0;
    logic       v1;
    logic [7:0] o0;
    logic [7:0] o1;
  } exp_t;

  exp_t exp_q[$];

  demux1x2_8bits #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .out0       (out0),
    .valid_out0 (valid_out0),
    .out1       (out1),
    .valid_out1 (valid_out1),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Queue an expected lane output for the cycle after the next edge.
  task automatic expect_out(input logic v0, input logic v1, input logic [7:0] o0, input logic [7:0] o1);
    exp_t e;
    e.cyc = cyc + 1;
    e.v0 = v0;
    e.v1 = v1;
    e.o0 = o0;
    e.o1 = o1;
    exp_q.push_back(e);
  endtask

  // Present one input for exactly one rising edge, return just after it.
  task automatic drive(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    $display("cycle %0d: valid_in=%0b data_in=0x%02h -> v0=%0b out0=0x%02h v1=%0b out1=0x%02h pending=%0b",
             cyc, v, d, valid_out0, out0, valid_out1, out1, pending);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out0"}, 32'(out0), 32'h0);
    check({name, "_out1"}, 32'(out1), 32'h0);
    check({name, "_valids"}, 32'({valid_out0, valid_out1}), 32'h0);
    check({name, "_pending"}, 32'(pending), 32'h0);
  endtask

  // Async reset pulse strictly between clock edges; outputs must clear at once.
  task automatic async_reset_pulse(input string name);
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    check_all_zero(name);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a valid output must match the queue head.
  always @(negedge clk) begin
    if (reset_L && (valid_out0 || valid_out1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: actual v0=%0b v1=%0b out0=0x%02h out1=0x%02h required no valid (cycle %0d)",
                 valid_out0, valid_out1, out0, out1, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_cycle", 32'(cyc), 32'(e.cyc));
        check("mon_valids", 32'({valid_out0, valid_out1}), 32'({e.v0, e.v1}));
        check("mon_out0", 32'(out0), 32'(e.o0));
        check("mon_out1", 32'(out1), 32'(e.o1));
        $display("cycle %0d: monitor v0=%0b out0=0x%02h v1=%0b out1=0x%02h", cyc, valid_out0, out0, valid_out1, out1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;

`ifdef DEMUX_PAIR_ALIGN_EN
    // 0xC3, two idle cycles, 0x3C: pending for 3 cycles, then one paired pulse.
    drive(1'b1, 8'hC3);
    check("pend_c1", 32'(pending), 32'h1);
    drive(1'b0, 8'h00);
    check("pend_c2", 32'(pending), 32'h1);
    drive(1'b0, 8'h00);
    check("pend_c3", 32'(pending), 32'h1);
    expect_out(1'b1, 1'b1, 8'hC3, 8'h3C);
    drive(1'b1, 8'h3C);
    check("pend_clear", 32'(pending), 32'h0);
    drive(1'b0, 8'h00);

    // 0x99 dropped by reset before its partner arrives.
    drive(1'b1, 8'h99);
    check("pend_99", 32'(pending), 32'h1);
    async_reset_pulse("pair_reset");
    drive(1'b1, 8'h10);
    check("pend_10", 32'(pending), 32'h1);
    expect_out(1'b1, 1'b1, 8'h10, 8'h20);
    drive(1'b1, 8'h20);
    check("pend_20_clear", 32'(pending), 32'h0);
    drive(1'b0, 8'h00);
`else
    // Back-to-back bytes alternate lanes with one-cycle latency.
    expect_out(1'b1, 1'b0, 8'h11, 8'h00);
    drive(1'b1, 8'h11);
    expect_out(1'b0, 1'b1, 8'h11, 8'h22);
    drive(1'b1, 8'h22);
    expect_out(1'b1, 1'b0, 8'h33, 8'h22);
    drive(1'b1, 8'h33);
    expect_out(1'b0, 1'b1, 8'h33, 8'h44);
    drive(1'b1, 8'h44);
    drive(1'b0, 8'h00);

    // Selector holds across an idle gap; out0 keeps its value with valid low.
    expect_out(1'b1, 1'b0, 8'hA5, 8'h44);
    drive(1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'hFF);
      check("gap_out0", 32'(out0), 32'hA5);
      check("gap_valid0", 32'(valid_out0), 32'h0);
    end
    expect_out(1'b0, 1'b1, 8'hA5, 8'h5A);
    drive(1'b1, 8'h5A);
    drive(1'b0, 8'h00);

    // 0x7E leaves the selector on lane 1; reset must bring it back to lane 0.
    expect_out(1'b1, 1'b0, 8'h7E, 8'h5A);
    drive(1'b1, 8'h7E);
    async_reset_pulse("async_reset");
    expect_out(1'b1, 1'b0, 8'h01, 8'h00);
    drive(1'b1, 8'h01);

    // Random data with valid_in low must change nothing.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'($urandom));
      check("idle_out0", 32'(out0), 32'h01);
      check("idle_out1", 32'(out1), 32'h00);
      check("idle_valids", 32'({valid_out0, valid_out1}), 32'h0);
      check("idle_pending", 32'(pending), 32'h0);
    end
`endif

    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
